uadd_5: RTL and testbench

Registered 5-bit unsigned saturating adder with overflow flag. It adds two unsigned operands each clock. On overflow it clamps the sum to the maximum representable value and raises `of`. It is a leaf arithmetic block for datapaths that need bounded unsigned accumulation without wrap-around artefacts.

---
 rtl/uadd_5.sv | 37 +++
 tb/tb_uadd_5.sv | 73 +++++++
 2 files changed

// File: rtl/uadd_5.sv
// uadd_5: registered unsigned saturating adder with overflow flag.
// Define UADD5_INREG_EN to add an input register stage (2-cycle latency).
module uadd_5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             of
);
  logic [WIDTH-1:0] ar, br;
  logic [WIDTH:0]   sum;
`ifdef UADD5_INREG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ar <= '0;
      br <= '0;
    end else begin
      ar <= a;
      br <= b;
    end
`else
  assign ar = a;
  assign br = b;
`endif
  assign sum = {1'b0, ar} + {1'b0, br};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s  <= '0;
      of <= 1'b0;
    end else begin
      s  <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      of <= sum[WIDTH];
    end
endmodule

// File: tb/tb_uadd_5.sv
// tb_uadd_5: scoreboard bench for uadd_5; latency follows UADD5_INREG_EN.
module tb_uadd_5;
  localparam int W = 5;
`ifdef UADD5_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1;
  logic [W-1:0] a = '0, b = '0, s;
  logic of;
  int errs = 0, checks = 0;
  logic [W:0] q[$];
  always #5 clk = ~clk;
  uadd_5 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .a(a), .b(b), .s(s), .of(of));
  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got of=%0d s=%0d, expected of=%0d s=%0d", tag, got[W], got[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask
  function automatic logic [W:0] model(input int x, input int y);
    int t = x + y;
    return t > (1 << W) - 1 ? {1'b1, {W{1'b1}}} : {1'b0, W'(t)};
  endfunction
  task automatic prefill();
    q.delete();
    repeat (LAT - 1) q.push_back('0);
  endtask
  task automatic step(input int x, input int y, input string tag);
    a = W'(x);
    b = W'(y);
    q.push_back(model(x, y));
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      errs++;
      $display("FAIL %s: scoreboard empty", tag);
    end else chk(tag, {of, s}, q.pop_front());
  endtask
  initial begin
    #1 chk("reset_init", {of, s}, '0);
    @(posedge clk);
    #1 chk("reset_held", {of, s}, '0);
    rst = 0;
    prefill();
    step(5, 9, "nominal");
    step(31, 1, "overflow");
    step(16, 15, "exact_max_sum");
    step(31, 0, "max_plus_0");
    step(0, 0, "zero");
    step(31, 31, "alt_1");
    step(0, 0, "alt_0");
    step(31, 31, "alt_1b");
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        step(i, j, "sweep");
    step(31, 31, "pre_rst");
    #3 rst = 1;
    #1 chk("async_rst", {of, s}, '0);
    @(posedge clk);
    #1 chk("rst_hold", {of, s}, '0);
    rst = 0;
    #1 chk("post_release", {of, s}, '0);
    prefill();
    step(5, 9, "after_rst");
    step(20, 20, "after_rst_ovf");
    step(7, 8, "after_rst_2");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
